// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU op codes, forward selects and multiplier FSM states
// Purpose: constants and types shared by the execute stage and its multiplier.
// Ports: none (package).
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUM    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - 32-step shift-add multiplier producing the low product word
// Purpose: latches operands on start in IDLE, iterates 32 shift-add steps in MUL,
//          presents the product for one cycle in DONE.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   start    in   multiply requested by the instruction in execute
//   a, b     in   multiplicand / multiplier, sampled only in IDLE
//   busy     out  high while upstream must hold (start in IDLE, or MUL)
//   done     out  high in DONE; product is valid
//   product  out  low WIDTH bits of a*b
import riscv_pkg::*;

module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [4:0]       count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          // Only the low word is kept, so bits shifted out of mcand never matter.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // busy covers the IDLE launch cycle too, so the ID/EX register holds the mul
  // from the very first cycle; DONE is deliberately not busy so upstream advances.
  assign busy    = (state == MUL) || ((state == IDLE) && start);
  assign done    = (state == DONE);
  assign product = acc;

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RV32 execute stage: forwarding, ALU, branch and E/M register
// Purpose: resolves forwarded operands, computes ALU/branch results, sequences
//          multi-cycle mul through mul_iter and registers the E/M outputs.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   RegWriteE..ALUSrcE, ALUControlE   ID/EX controls
//   ForwardA_E, ForwardB_E            operand forward selects
//   RD_E, RD1_E, RD2_E, Imm_Ext_E     ID/EX destination and data
//   PCE, PCPlus4E                     ID/EX program counters
//   ResultW                           writeback forward source
//   PCSrcE, PCTargetE                 combinational branch decision / target
//   BusyE                             combinational stall request
//   RegWriteM..ALU_ResultM            registered E/M outputs
import riscv_pkg::*;

module execute_cycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             ResultSrcE,
  input  logic             BranchE,
  input  logic             ALUSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  input  logic [4:0]       RD_E,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] Imm_Ext_E,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [WIDTH-1:0] ResultW,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             BusyE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [4:0]       RD_M,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ALU_ResultM
);

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] mul_product;
  logic             mul_busy;
  logic             mul_done;
  logic             zero;

  always_comb begin
    case (ForwardA_E)
      FWD_RESULTW: src_a = ResultW;
      FWD_ALUM:    src_a = ALU_ResultM;
      FWD_REG:     src_a = RD1_E;
      default:     src_a = RD1_E;
    endcase
  end

  always_comb begin
    case (ForwardB_E)
      FWD_RESULTW: write_data = ResultW;
      FWD_ALUM:    write_data = ALU_ResultM;
      FWD_REG:     write_data = RD2_E;
      default:     write_data = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : write_data;
  assign diff  = src_a - src_b;
  assign zero  = (diff == '0);

  // mul and the reserved codes fall to 0; the mul result is substituted in DONE.
  always_comb begin
    case (ALUControlE)
      ALU_ADD: alu_out = src_a + src_b;
      ALU_SUB: alu_out = diff;
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_out = '0;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (ALUControlE == ALU_MUL),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign alu_result = mul_done ? mul_product : alu_out;
  assign BusyE      = mul_busy;
  assign PCTargetE  = PCE + Imm_Ext_E;
  // A held mul can never be a taken branch; suppress PCSrcE for the whole sequence.
  assign PCSrcE     = BranchE & zero & ~mul_busy & ~mul_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (mul_busy) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= write_data;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - self-checking bench for execute_cycle
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [4:0]  RD_E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        BusyE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int total = 0;
  int bad   = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .RD_E(RD_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  fa;
    logic        src;
    logic        br;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] rw;
    logic [31:0] exp_alu;
    logic        exp_pcsrc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_idle_ctrl();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
    ALUControlE = 3'b000; ForwardA_E = 2'b00; ForwardB_E = 2'b00; RD_E = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 32'h40; PCPlus4E = 32'h44; ResultW = 0;
  endtask

  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [1:0] fb, input logic br,
                         input logic [31:0] exp);
    int busy_cnt;
    logic bubble_ok;
    logic pc_ok;
    ALUControlE = 3'b100; ForwardA_E = fa; ForwardB_E = fb; ALUSrcE = 0;
    RD1_E = a; RD2_E = b; ResultW = a; BranchE = br; RD_E = 5'd9;
    RegWriteE = 1; MemWriteE = 0; ResultSrcE = 0;
    busy_cnt = 0; bubble_ok = 1; pc_ok = 1;
    #1;
    for (int n = 0; n < 40 && BusyE; n++) begin
      busy_cnt++;
      @(posedge clk); #1;
      if (RegWriteM || MemWriteM || ResultSrcM || RD_M != 0 || ALU_ResultM != 0) bubble_ok = 0;
      if (PCSrcE) pc_ok = 0;
      // Forward sources move during the stall; the latched operands must not.
      ResultW = $urandom;
      #1;
    end
    chk({nm, "_busy_cycles"}, busy_cnt, 33);
    chk({nm, "_bubbles"}, {31'd0, bubble_ok}, 1);
    chk({nm, "_pcsrc_stall"}, {31'd0, pc_ok}, 1);
    @(posedge clk); #1;
    chk({nm, "_product"}, ALU_ResultM, exp);
    chk({nm, "_rd_m"}, {27'd0, RD_M}, 9);
    chk({nm, "_regwrite_m"}, {31'd0, RegWriteM}, 1);
  endtask

  initial begin
    //          op      fa     src br  rd1           rd2           imm       rw          exp_alu       pc
    vecs[0]  = '{3'b000, 2'b00, 0, 0, 32'd3,        32'd4,        32'h0,    32'h0,      32'd7,        0};
    vecs[1]  = '{3'b001, 2'b00, 0, 0, 32'd3,        32'd5,        32'h0,    32'h0,      32'hFFFFFFFE, 0};
    vecs[2]  = '{3'b010, 2'b00, 0, 0, 32'hF0F0,     32'hFF00,     32'h0,    32'h0,      32'hF000,     0};
    vecs[3]  = '{3'b011, 2'b00, 0, 0, 32'hF0F0,     32'h0F0F,     32'h0,    32'h0,      32'hFFFF,     0};
    vecs[4]  = '{3'b101, 2'b00, 0, 0, 32'hFFFFFFFF, 32'd1,        32'h0,    32'h0,      32'd1,        0};
    vecs[5]  = '{3'b101, 2'b00, 0, 0, 32'd1,        32'hFFFFFFFF, 32'h0,    32'h0,      32'd0,        0};
    vecs[6]  = '{3'b000, 2'b00, 1, 0, 32'hA,        32'h99,       32'h20,   32'h0,      32'h2A,       0};
    vecs[7]  = '{3'b110, 2'b00, 0, 0, 32'd3,        32'd4,        32'h0,    32'h0,      32'd0,        0};
    vecs[8]  = '{3'b111, 2'b00, 0, 0, 32'd3,        32'd4,        32'h0,    32'h0,      32'd0,        0};
    vecs[9]  = '{3'b001, 2'b00, 0, 1, 32'h10,       32'h10,       32'h8,    32'h0,      32'd0,        1};
    vecs[10] = '{3'b001, 2'b00, 0, 1, 32'h10,       32'h11,       32'h8,    32'h0,      32'hFFFFFFFF, 0};
    vecs[11] = '{3'b000, 2'b01, 0, 0, 32'hDEAD,     32'd1,        32'h0,    32'h100,    32'h101,      0};
    vecs[12] = '{3'b000, 2'b00, 0, 0, 32'hFFFFFFFF, 32'd2,        32'h0,    32'h0,      32'd1,        0};

    set_idle_ctrl();
    rst = 1'b0;
    #3;
    chk("reset_alu_m", ALU_ResultM, 0);
    chk("reset_rd_m", {27'd0, RD_M}, 0);
    chk("reset_ctrl_m", {29'd0, RegWriteM, MemWriteM, ResultSrcM}, 0);
    chk("reset_busy", {31'd0, BusyE}, 0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      ALUControlE = vecs[i].op; ForwardA_E = vecs[i].fa; ForwardB_E = 2'b00;
      ALUSrcE = vecs[i].src; BranchE = vecs[i].br; RD1_E = vecs[i].rd1;
      RD2_E = vecs[i].rd2; Imm_Ext_E = vecs[i].imm; ResultW = vecs[i].rw;
      RD_E = 5'(i + 1); RegWriteE = i[0]; MemWriteE = ~i[0]; ResultSrcE = i[1];
      #1;
      chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, vecs[i].exp_pcsrc});
      chk($sformatf("v%0d_target", i), PCTargetE, 32'h40 + vecs[i].imm);
      chk($sformatf("v%0d_busy", i), {31'd0, BusyE}, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_alu_m", i), ALU_ResultM, vecs[i].exp_alu);
      chk($sformatf("v%0d_rd_m", i), {27'd0, RD_M}, 32'(i + 1));
      chk($sformatf("v%0d_ctrl_m", i), {29'd0, RegWriteM, MemWriteM, ResultSrcM},
          {29'd0, i[0], ~i[0], i[1]});
      chk($sformatf("v%0d_wdata_m", i), WriteDataM, vecs[i].rd2);
      chk($sformatf("v%0d_pc4_m", i), PCPlus4M, 32'h44);
    end

    // Forward from ALU_ResultM: 2+3 lands in E/M, then 5+7 via ForwardA_E=10.
    set_idle_ctrl();
    RD1_E = 2; RD2_E = 3; RegWriteE = 1; RD_E = 3;
    @(posedge clk); #1;
    chk("fwd_setup", ALU_ResultM, 5);
    ForwardA_E = 2'b10; RD1_E = 32'hBAD; RD2_E = 7; RegWriteE = 1; RD_E = 4;
    @(posedge clk); #1;
    chk("fwd_alu_m", ALU_ResultM, 12);
    chk("fwd_regwrite_m", {31'd0, RegWriteM}, 1);

    // Back-to-back multiplies.
    run_mul("mul7x6", 32'd7, 32'd6, 2'b00, 2'b00, 1'b0, 32'd42);
    run_mul("mulneg", 32'hFFFFFFFF, 32'd3, 2'b01, 2'b00, 1'b0, 32'hFFFFFFFD);
    run_mul("mulbr", 32'd5, 32'd5, 2'b01, 2'b01, 1'b1, 32'd25);

    // Reset in the middle of a multiply.
    set_idle_ctrl();
    ALUControlE = 3'b100; RD1_E = 7; RD2_E = 6; RD_E = 9; RegWriteE = 1;
    repeat (11) @(posedge clk);
    #1;
    chk("abort_busy_before", {31'd0, BusyE}, 1);
    rst = 1'b0;
    #1;
    chk("abort_alu_m", ALU_ResultM, 0);
    chk("abort_ctrl_m", {29'd0, RegWriteM, MemWriteM, ResultSrcM}, 0);
    chk("abort_rd_m", {27'd0, RD_M}, 0);
    set_idle_ctrl();
    RD1_E = 2; RD2_E = 3; RD_E = 4; RegWriteE = 1;
    #1 rst = 1'b1;
    #1;
    chk("abort_busy_after", {31'd0, BusyE}, 0);
    @(posedge clk); #1;
    chk("abort_add_alu_m", ALU_ResultM, 5);
    chk("abort_add_rd_m", {27'd0, RD_M}, 4);

    // Accumulator must start clean after the aborted multiply.
    run_mul("mul_after_rst", 32'd3, 32'd4, 2'b00, 2'b00, 1'b0, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
